// File: rtl/class_mem_bank_loader_if.sv
// Load/read bundle for class_mem_bank_loader; rd_err is present only when
// CLASS_MEM_RD_RANGE_CHECK_EN is defined.
interface class_mem_bank_loader_if #(
   parameter int FTWIDTH    = 8,
   parameter int M_SIZE     = 16,
   parameter int ADDR_WIDTH = 13
);
   logic                        start;
   logic                        clear;
   logic                        wr_valid;
   logic [FTWIDTH-1:0]          wr_data;
   logic                        wr_ready;
   logic                        load_done;
   logic [31:0]                 words_loaded;
   logic                        rd_en;
   logic [ADDR_WIDTH-1:0]       rd_addr;
   logic [M_SIZE*FTWIDTH-1:0]   rd_data;
   logic                        rd_valid;
`ifdef CLASS_MEM_RD_RANGE_CHECK_EN
   logic                        rd_err;

   modport master (
      output start, clear, wr_valid, wr_data, rd_en, rd_addr,
      input  wr_ready, load_done, words_loaded, rd_data, rd_valid, rd_err
   );
   modport slave (
      input  start, clear, wr_valid, wr_data, rd_en, rd_addr,
      output wr_ready, load_done, words_loaded, rd_data, rd_valid, rd_err
   );
`else
   modport master (
      output start, clear, wr_valid, wr_data, rd_en, rd_addr,
      input  wr_ready, load_done, words_loaded, rd_data, rd_valid
   );
   modport slave (
      input  start, clear, wr_valid, wr_data, rd_en, rd_addr,
      output wr_ready, load_done, words_loaded, rd_data, rd_valid
   );
`endif
endinterface

// File: rtl/class_mem_bank_loader.sv
// Streams class elements round-robin into M_SIZE banks, then serves wide reads (latency 1).
// Optional out-of-range read flag under CLASS_MEM_RD_RANGE_CHECK_EN.
module class_mem_bank_loader #(
   parameter int FTWIDTH    = 8,
   parameter int M_SIZE     = 16,
   parameter int DEPTH      = 6500,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                      clk,
   input  logic                      reset,
   class_mem_bank_loader_if.slave    bus
);
   localparam int BW = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
   localparam logic [BW-1:0]         LAST_BANK = BW'(M_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                    state_q, state_d;
   logic [BW-1:0]             bank_idx_q, bank_idx_d;
   logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
   logic [31:0]               words_q, words_d;
   logic                      rd_valid_q;
   logic [M_SIZE*FTWIDTH-1:0] rd_data_q;
   logic [M_SIZE*FTWIDTH-1:0] rd_word;
   logic                      wr_ready;
   logic                      wr_xfer;
   logic                      rd_accept;

   logic [FTWIDTH-1:0] mem [M_SIZE][DEPTH];

   assign wr_ready  = (state_q == LOAD) && !bus.clear;
   assign wr_xfer   = bus.wr_valid && wr_ready;
   assign rd_accept = bus.rd_en && (state_q != LOAD);

   assign bus.wr_ready     = wr_ready;
   assign bus.load_done    = (state_q == DONE);
   assign bus.words_loaded = words_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_data      = rd_data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         bank_idx_q <= '0;
         wr_addr_q  <= '0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         bank_idx_q <= bank_idx_d;
         wr_addr_q  <= wr_addr_d;
         words_q    <= words_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bank_idx_d = bank_idx_q;
      wr_addr_d  = wr_addr_q;
      words_d    = words_q;
      if (bus.clear) begin
         state_d    = IDLE;
         bank_idx_d = '0;
         wr_addr_d  = '0;
         words_d    = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_d    = LOAD;
                  bank_idx_d = '0;
                  wr_addr_d  = '0;
                  words_d    = '0;
               end
            end
            LOAD: begin
               // A stalled cycle leaves bank_idx alone, so no bank is ever skipped.
               if (wr_xfer) begin
                  words_d = words_q + 32'd1;
                  if (bank_idx_q == LAST_BANK) begin
                     bank_idx_d = '0;
                     if (wr_addr_q == LAST_ADDR) begin
                        state_d   = DONE;
                        wr_addr_d = '0;
                     end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                     end
                  end else begin
                     bank_idx_d = bank_idx_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Storage is deliberately outside the reset domain: contents survive reset and clear.
   always_ff @(posedge clk) begin
      if (wr_xfer) begin
         mem[bank_idx_q][wr_addr_q] <= bus.wr_data;
      end
   end

   always_comb begin
      rd_word = '0;
      for (int b = 0; b < M_SIZE; b++) begin
         rd_word[b*FTWIDTH +: FTWIDTH] = mem[b][bus.rd_addr];
      end
   end

`ifdef CLASS_MEM_RD_RANGE_CHECK_EN
   logic rd_err_q;
   logic rd_oob;

   assign rd_oob     = (32'(bus.rd_addr) >= 32'(DEPTH));
   assign bus.rd_err = rd_err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_accept;
         rd_err_q   <= rd_accept && rd_oob;
         if (rd_accept) begin
            rd_data_q <= rd_oob ? '0 : rd_word;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_accept;
         if (rd_accept) begin
            rd_data_q <= rd_word;
         end
      end
   end
`endif

endmodule

// File: tb/tb_class_mem_bank_loader.sv
// Randomized bench for class_mem_bank_loader (M_SIZE=4, DEPTH=8) against a flat
// word-index reference model: word k lives in bank k%M at address k/M.
module tb_class_mem_bank_loader;
   localparam int FT = 8;
   localparam int M  = 4;
   localparam int D  = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [FT-1:0] ref_mem [M][D];
   int            exp_words = 0;
   bit            exp_load  = 0;
   bit            exp_done  = 0;

   class_mem_bank_loader_if #(.FTWIDTH(FT), .M_SIZE(M), .ADDR_WIDTH(AW)) bus ();

   class_mem_bank_loader #(
      .FTWIDTH(FT), .M_SIZE(M), .DEPTH(D), .ADDR_WIDTH(AW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [M*FT-1:0] model_word(input int a);
      logic [M*FT-1:0] w;
      for (int b = 0; b < M; b++) w[b*FT +: FT] = ref_mem[b][a];
      return w;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      exp_load  = 1;
      exp_done  = 0;
      exp_words = 0;
   endtask

   task automatic do_read(input int a, output logic v1, output logic [M*FT-1:0] d,
                          output logic e1, output logic v2, output logic e2);
      @(negedge clk);
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(a);
      @(negedge clk);
      bus.rd_en = 1'b0;
      v1 = bus.rd_valid;
      d  = bus.rd_data;
`ifdef CLASS_MEM_RD_RANGE_CHECK_EN
      e1 = bus.rd_err;
`else
      e1 = 1'b0;
`endif
      @(negedge clk);
      v2 = bus.rd_valid;
`ifdef CLASS_MEM_RD_RANGE_CHECK_EN
      e2 = bus.rd_err;
`else
      e2 = 1'b0;
`endif
   endtask

   // gap_mode: 0 = valid every cycle, 1 = strict 1-0-1 toggle, 2 = random gaps
   task automatic stream(input int n, input int gap_mode, input bit seq_data, input bit rd_during);
      int sent = 0;
      int cyc = 0;
      bit toggle = 1;
      logic v;
      logic [M*FT-1:0] held;
      held = bus.rd_data;
      while (sent < n && cyc < 400) begin
         @(negedge clk);
         total++;
         if (bus.words_loaded !== 32'(exp_words)) begin
            bad++;
            $display("FAIL stream_words got=%0d want=%0d", bus.words_loaded, exp_words);
         end
         total++;
         if (bus.wr_ready !== exp_load) begin
            bad++;
            $display("FAIL stream_wr_ready got=%b want=%b", bus.wr_ready, exp_load);
         end
         total++;
         if (bus.load_done !== 1'b0) begin
            bad++;
            $display("FAIL stream_load_done got=%b want=0", bus.load_done);
         end
         if (rd_during) begin
            total++;
            if (bus.rd_valid !== 1'b0 || bus.rd_data !== held) begin
               bad++;
               $display("FAIL rd_in_load valid=%b data=%h want valid=0 data=%h",
                        bus.rd_valid, bus.rd_data, held);
            end
            bus.rd_en   = 1'b1;
            bus.rd_addr = AW'($urandom_range(0, D-1));
         end
         v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? toggle : 1'($urandom_range(0, 1));
         toggle = !toggle;
         bus.wr_valid = v;
         bus.wr_data  = seq_data ? FT'(exp_words) : FT'($urandom);
         if (v && exp_load) begin
            ref_mem[exp_words % M][exp_words / M] = bus.wr_data;
            exp_words++;
            sent++;
            if (exp_words == M*D) begin
               exp_load = 0;
               exp_done = 1;
            end
         end
         cyc++;
      end
      if (sent < n) begin
         total++;
         bad++;
         $display("FAIL stream_timeout sent=%0d want=%0d", sent, n);
      end
      @(negedge clk);
      bus.wr_valid = 1'b0;
      bus.rd_en    = 1'b0;
   endtask

   task automatic check_done(input string tag);
      total++;
      if (bus.load_done !== 1'b1 || bus.words_loaded !== 32'(M*D)) begin
         bad++;
         $display("FAIL %s_done load_done=%b words=%0d want 1/%0d", tag,
                  bus.load_done, bus.words_loaded, M*D);
      end
   endtask

   task automatic check_all_reads(input string tag);
      logic v1, e1, v2, e2;
      logic [M*FT-1:0] d;
      for (int a = 0; a < D; a++) begin
         do_read(a, v1, d, e1, v2, e2);
         total++;
         if (v1 !== 1'b1 || v2 !== 1'b0 || d !== model_word(a)) begin
            bad++;
            $display("FAIL %s_read addr=%0d valid=%b/%b data=%h want 1/0 %h",
                     tag, a, v1, v2, d, model_word(a));
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 0; bus.clear = 0; bus.wr_valid = 0; bus.wr_data = '0;
      bus.rd_en = 0; bus.rd_addr = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      total++;
      if (bus.wr_ready !== 1'b0 || bus.load_done !== 1'b0 || bus.words_loaded !== 32'd0 ||
          bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
         bad++;
         $display("FAIL reset_outputs rdy=%b done=%b words=%0d rv=%b rd=%h want all 0",
                  bus.wr_ready, bus.load_done, bus.words_loaded, bus.rd_valid, bus.rd_data);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (bus.wr_ready !== 1'b0 || bus.load_done !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset rdy=%b done=%b want 0/0", bus.wr_ready, bus.load_done);
      end
   endtask

   task automatic test_full_load();
      logic v1, e1, v2, e2;
      logic [M*FT-1:0] d, want;
      pulse_start();
      stream(M*D, 0, 1, 0);
      check_done("full");
      do_read(2, v1, d, e1, v2, e2);
      for (int b = 0; b < M; b++) want[b*FT +: FT] = FT'(2*M + b);
      total++;
      if (v1 !== 1'b1 || v2 !== 1'b0 || d !== want) begin
         bad++;
         $display("FAIL full_read2 valid=%b/%b data=%h want 1/0 %h", v1, v2, d, want);
      end
   endtask

   task automatic test_toggle();
      pulse_start();
      stream(M*D, 1, 1, 0);
      check_done("toggle");
      check_all_reads("toggle");
   endtask

   task automatic test_read_in_load();
      logic v1, e1, v2, e2;
      logic [M*FT-1:0] d, want;
      pulse_start();
      stream(M*D, 2, 1, 1);
      check_done("rdload");
      do_read(7, v1, d, e1, v2, e2);
      for (int b = 0; b < M; b++) want[b*FT +: FT] = FT'(7*M + b);
      total++;
      if (v1 !== 1'b1 || d !== want) begin
         bad++;
         $display("FAIL rdload_read7 valid=%b data=%h want 1 %h", v1, d, want);
      end
   endtask

   task automatic test_clear();
      pulse_start();
      stream(10, 2, 0, 0);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if (bus.words_loaded !== 32'd10 || bus.wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL start_in_load words=%0d rdy=%b want 10/1", bus.words_loaded, bus.wr_ready);
      end
      bus.clear = 1'b1;
      bus.start = 1'b1;
      #1;
      total++;
      if (bus.wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL clear_wr_ready got=%b want=0", bus.wr_ready);
      end
      @(negedge clk);
      bus.clear = 1'b0;
      bus.start = 1'b0;
      exp_load  = 0;
      exp_words = 0;
      total++;
      if (bus.words_loaded !== 32'd0 || bus.load_done !== 1'b0 || bus.wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL clear_state words=%0d done=%b rdy=%b want 0/0/0",
                  bus.words_loaded, bus.load_done, bus.wr_ready);
      end
      @(negedge clk);
      total++;
      if (bus.wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL clear_beats_start rdy=%b want=0", bus.wr_ready);
      end
      check_all_reads("clear");
   endtask

   task automatic test_reset_mid();
      pulse_start();
      stream(5, 0, 0, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      total++;
      if (bus.wr_ready !== 1'b0 || bus.load_done !== 1'b0 || bus.words_loaded !== 32'd0 ||
          bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
         bad++;
         $display("FAIL async_reset rdy=%b done=%b words=%0d rv=%b rd=%h want all 0",
                  bus.wr_ready, bus.load_done, bus.words_loaded, bus.rd_valid, bus.rd_data);
      end
      @(negedge clk);
      reset     = 1'b1;
      exp_load  = 0;
      exp_words = 0;
      pulse_start();
      stream(M*D, 2, 0, 0);
      check_done("restart");
      check_all_reads("restart");
   endtask

   task automatic test_range();
`ifdef CLASS_MEM_RD_RANGE_CHECK_EN
      logic v1, e1, v2, e2;
      logic [M*FT-1:0] d;
      do_read(9, v1, d, e1, v2, e2);
      total++;
      if (v1 !== 1'b1 || e1 !== 1'b1 || d !== '0 || e2 !== 1'b0 || v2 !== 1'b0) begin
         bad++;
         $display("FAIL range_oob valid=%b err=%b/%b data=%h want 1 1/0 0", v1, e1, e2, d);
      end
      do_read(1, v1, d, e1, v2, e2);
      total++;
      if (e1 !== 1'b0 || d !== model_word(1)) begin
         bad++;
         $display("FAIL range_inb err=%b data=%h want 0 %h", e1, d, model_word(1));
      end
`endif
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_toggle();
      test_read_in_load();
      test_clear();
      test_reset_mid();
      test_range();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/class_mem_bank_loader.md
CLASS_MEM_BANK_LOADER -- requirements
Module: class_mem_bank_loader

Interface
REQ-001 SHALL have parameter FTWIDTH, default 8, bit width of one class element.
REQ-002 SHALL have parameter M_SIZE, default 16, number of parallel banks (>=2).
REQ-003 SHALL have parameter DEPTH, default 6500, words per bank (>=2).
REQ-004 SHALL have parameter ADDR_WIDTH, default 13, bank address width; 2**ADDR_WIDTH >= DEPTH.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  pulse begins a full load.
REQ-008 SHALL have port clear  input  1  synchronous abort to IDLE.
REQ-009 SHALL have port wr_valid  input  1  wr_data is valid.
REQ-010 SHALL have port wr_data  input  FTWIDTH  class element stream.
REQ-011 SHALL have port wr_ready  output  1  block accepts wr_data.
REQ-012 SHALL have port load_done  output  1  all M_SIZE*DEPTH words stored.
REQ-013 SHALL have port words_loaded  output  32  accepted-word count of current load.
REQ-014 SHALL have port rd_en  input  1  read request.
REQ-015 SHALL have port rd_addr  input  ADDR_WIDTH  read word address.
REQ-016 SHALL have port rd_data  output  M_SIZE*FTWIDTH  bank b at bits [b*FTWIDTH +: FTWIDTH].
REQ-017 SHALL have port rd_valid  output  1  rd_data updated this cycle.

Function
REQ-018 SHALL implement states IDLE, LOAD, DONE; storage is internal, M_SIZE banks x DEPTH x FTWIDTH.
REQ-019 IDLE: start -> LOAD, bank index and word address cleared to 0, words_loaded cleared to 0.
REQ-020 wr_ready SHALL be 1 exactly when state is LOAD and clear is 0; a transfer occurs on wr_valid & wr_ready.
REQ-021 Each transfer SHALL write wr_data to bank[bank_idx][wr_addr], increment words_loaded, then bank_idx+1; on bank_idx==M_SIZE-1 wrap bank_idx to 0 and increment wr_addr.
REQ-022 wr_valid low in LOAD SHALL stall with no state change (no bank skipping).
REQ-023 Transfer with bank_idx==M_SIZE-1 and wr_addr==DEPTH-1 SHALL enter DONE; load_done=1 from the next cycle.
REQ-024 DONE: start SHALL re-enter LOAD as in REQ-019 and drop load_done the next cycle; prior contents remain until overwritten.
REQ-025 start in LOAD SHALL be ignored; start and clear in same cycle: clear wins.
REQ-026 clear SHALL force IDLE, load_done=0, words_loaded=0 next cycle; memory contents unchanged.
REQ-027 Reads SHALL be accepted when rd_en=1 and state!=LOAD; rd_data = all banks at rd_addr and rd_valid=1 one cycle later (latency 1).
REQ-028 rd_en during LOAD SHALL be ignored (rd_valid=0, rd_data held).
REQ-029 rd_valid SHALL be a single-cycle pulse per accepted read; rd_data holds last value otherwise.
REQ-030 A write and read SHALL never coincide (reads blocked in LOAD), so no collision rule is needed.

Reset
REQ-031 reset low SHALL asynchronously set state IDLE, bank_idx 0, wr_addr 0, words_loaded 0, load_done 0, rd_valid 0, rd_data 0, wr_ready 0.
REQ-032 reset mid-LOAD SHALL discard progress; memory contents are not cleared.

Configuration
REQ-033 Macro CLASS_MEM_RD_RANGE_CHECK_EN defined: output rd_err (1 bit, reset 0) pulses with rd_valid when accepted rd_addr >= DEPTH, and rd_data is all-zero for that read.
REQ-034 Macro undefined: no rd_err port; rd_addr >= DEPTH yields unspecified rd_data, no other effect.

Verification (M_SIZE=4, DEPTH=8, FTWIDTH=8)
REQ-035 start, stream 32 words value n=0..31 with wr_valid=1 -> load_done=1 cycle after 32nd transfer, words_loaded=32; read addr 2 -> rd_data = {11,10,9,8} one cycle later, rd_valid pulse.
REQ-036 wr_valid toggled 1-0-1 each cycle -> still exactly 32 transfers, identical contents to REQ-035.
REQ-037 After 10 transfers assert clear -> state IDLE, words_loaded=0, load_done=0; wr_ready=0.
REQ-038 rd_en=1 during LOAD -> rd_valid stays 0; after DONE, rd_en at addr 7 -> {31,30,29,28}.
REQ-039 reset low mid-LOAD asynchronously (between edges) -> all outputs zero immediately; restart loads cleanly.
REQ-040 With CLASS_MEM_RD_RANGE_CHECK_EN, read addr 9 after DONE -> rd_err=1, rd_data=0 for one cycle.
